// File: rtl/box_pkg.sv
// Shared constants and the column-sum helper for the 13x13 box-sum datapath.
package box_pkg;

  localparam int NUM_ROWS  = 13;
  localparam int WIN       = 13;
  localparam int PIX_W     = 8;
  localparam int COLSUM_W  = 12;
  localparam int SUM_W     = 16;
  localparam int WIN_START = WIN - 1;

  // Pairwise reduction keeps the tree shallow; 13*255 fits in COLSUM_W bits.
  function automatic logic [COLSUM_W-1:0] col_sum(input logic [NUM_ROWS-1:0][PIX_W-1:0] taps);
    logic [COLSUM_W-1:0] l1 [7];
    logic [COLSUM_W-1:0] l2 [4];
    l1[6] = COLSUM_W'(taps[12]);
    for (int i = 0; i < 6; i++) begin
      l1[i] = COLSUM_W'(taps[2*i]) + COLSUM_W'(taps[2*i+1]);
    end
    l2[3] = l1[6];
    for (int i = 0; i < 3; i++) begin
      l2[i] = l1[2*i] + l1[2*i+1];
    end
    return (l2[0] + l2[1]) + (l2[2] + l2[3]);
  endfunction

endpackage

// File: rtl/box_sum_13x13_if.sv
// Column-tap input bus and result outputs of the 13x13 box-sum stage.
interface box_sum_13x13_if;
  import box_pkg::*;

  logic             valid_i;
  logic             done_i;
  logic [PIX_W-1:0] data0_i, data1_i, data2_i, data3_i, data4_i, data5_i, data6_i;
  logic [PIX_W-1:0] data7_i, data8_i, data9_i, data10_i, data11_i, data12_i;
  logic [SUM_W-1:0] sum_o;
  logic             valid_o;
  logic             done_o;

  modport master (
    output valid_i, done_i,
    output data0_i, data1_i, data2_i, data3_i, data4_i, data5_i, data6_i,
    output data7_i, data8_i, data9_i, data10_i, data11_i, data12_i,
    input  sum_o, valid_o, done_o
  );

  modport slave (
    input  valid_i, done_i,
    input  data0_i, data1_i, data2_i, data3_i, data4_i, data5_i, data6_i,
    input  data7_i, data8_i, data9_i, data10_i, data11_i, data12_i,
    output sum_o, valid_o, done_o
  );

endinterface

// File: rtl/column_adder_13.sv
// Registered sum of the 13 vertical taps of one column, loaded only on enable.
module column_adder_13
  import box_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_en,
  input  logic [NUM_ROWS-1:0][PIX_W-1:0]   i_taps,
  output logic [COLSUM_W-1:0]              o_colsum
);

  logic [COLSUM_W-1:0] w_sum;
  logic [COLSUM_W-1:0] r_sum;

  always_comb begin
    w_sum = col_sum(i_taps);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sum <= {COLSUM_W{1'b0}};
    end else if (i_en) begin
      r_sum <= w_sum;
    end
  end

  assign o_colsum = r_sum;

endmodule

// File: rtl/box_sum_13x13.sv
// Running 13x13 box sum: column adder, then a per-row sliding accumulator
// that subtracts the column leaving the window.
module box_sum_13x13
  import box_pkg::*;
#(
  parameter int IMG_W = 17,
  parameter int IMG_H = 17,
  parameter int CNT_W = 10
) (
  input logic            clk,
  input logic            rst,
  box_sum_13x13_if.slave bus
);

  logic [NUM_ROWS-1:0][PIX_W-1:0] w_taps;
  logic [COLSUM_W-1:0]            w_colsum;
  logic [CNT_W-1:0]               r_col, r_row;
  logic [CNT_W-1:0]               r_c1, r_r1;
  logic                           r_v1, r_d1, r_d2;
  logic [COLSUM_W-1:0]            r_hist [WIN];
  logic [SUM_W-1:0]               r_acc, w_acc_nxt;
  logic                           r_valid, w_win_full, w_row_start;

  assign w_taps = {bus.data12_i, bus.data11_i, bus.data10_i, bus.data9_i, bus.data8_i,
                   bus.data7_i, bus.data6_i, bus.data5_i, bus.data4_i, bus.data3_i,
                   bus.data2_i, bus.data1_i, bus.data0_i};

  column_adder_13 u_col_add (
    .clk      (clk),
    .rst      (rst),
    .i_en     (bus.valid_i),
    .i_taps   (w_taps),
    .o_colsum (w_colsum)
  );

  // done_i wins over the advance, but stage 1 has already latched the pre-clear position.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col <= {CNT_W{1'b0}};
      r_row <= {CNT_W{1'b0}};
    end else if (bus.done_i) begin
      r_col <= {CNT_W{1'b0}};
      r_row <= {CNT_W{1'b0}};
    end else if (bus.valid_i) begin
      if (r_col == CNT_W'(IMG_W - 1)) begin
        r_col <= {CNT_W{1'b0}};
        if (r_row != CNT_W'(IMG_H - 1)) begin
          r_row <= r_row + CNT_W'(1);
        end
      end else begin
        r_col <= r_col + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1 <= 1'b0;
      r_c1 <= {CNT_W{1'b0}};
      r_r1 <= {CNT_W{1'b0}};
      r_d1 <= 1'b0;
      r_d2 <= 1'b0;
    end else begin
      r_v1 <= bus.valid_i;
      r_d1 <= bus.done_i;
      r_d2 <= r_d1;
      if (bus.valid_i) begin
        r_c1 <= r_col;
        r_r1 <= r_row;
      end
    end
  end

  always_comb begin
    w_acc_nxt   = r_acc + SUM_W'(w_colsum) - SUM_W'(r_hist[WIN-1]);
    w_row_start = (r_c1 == {CNT_W{1'b0}});
    w_win_full  = r_v1 && (r_c1 >= CNT_W'(WIN_START)) && (r_r1 >= CNT_W'(WIN_START));
  end

  // Column 0 restarts the window so nothing from the previous row leaks in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc   <= {SUM_W{1'b0}};
      r_valid <= 1'b0;
      for (int i = 0; i < WIN; i++) begin
        r_hist[i] <= {COLSUM_W{1'b0}};
      end
    end else begin
      r_valid <= w_win_full;
      if (r_v1) begin
        r_hist[0] <= w_colsum;
        if (w_row_start) begin
          r_acc <= SUM_W'(w_colsum);
          for (int i = 1; i < WIN; i++) begin
            r_hist[i] <= {COLSUM_W{1'b0}};
          end
        end else begin
          r_acc <= w_acc_nxt;
          for (int i = 1; i < WIN; i++) begin
            r_hist[i] <= r_hist[i-1];
          end
        end
      end
    end
  end

  assign bus.sum_o   = r_acc;
  assign bus.valid_o = r_valid;
  assign bus.done_o  = r_d2;

endmodule

// File: tb/tb_box_sum_13x13.sv
// Bench for box_sum_13x13: per-cycle reference of expected valid/sum/done,
// built from whole-row column sums rather than a sliding accumulator.
module tb_box_sum_13x13;
  import box_pkg::*;

  localparam int W = 17;
  localparam int H = 17;
  localparam int NF = 8;

  typedef struct {
    bit v;
    bit d;
    int sum;
    int cexp;
    int fid;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  box_sum_13x13_if bus();

  box_sum_13x13 #(.IMG_W(W), .IMG_H(H), .CNT_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   tests = 0;
  int   fails = 0;
  int   m_row = 0;
  int   m_col = 0;
  int   cs_row [W];
  int   mode  = 0;
  int   cval  = 0;
  int   fid   = 0;
  int   vcnt  [NF];
  exp_t q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int gen_tap(input int k);
    case (mode)
      0:       return cval;
      1:       return (m_row * 3 + m_col * 7 + k * 11) & 255;
      2:       return int'($urandom_range(255));
      3:       return (m_row % 2 == 0) ? 10 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic step(input bit v, input bit d);
    logic [12:0][7:0] t;
    int cs;
    exp_t e;
    cs = 0;
    for (int k = 0; k < 13; k++) begin
      t[k] = 8'(gen_tap(k));
      cs += int'(t[k]);
    end
    {bus.data12_i, bus.data11_i, bus.data10_i, bus.data9_i, bus.data8_i, bus.data7_i,
     bus.data6_i, bus.data5_i, bus.data4_i, bus.data3_i, bus.data2_i, bus.data1_i,
     bus.data0_i} = t;
    bus.valid_i = v;
    bus.done_i  = d;
    e.v = 1'b0; e.d = d; e.sum = 0; e.cexp = -1; e.fid = fid;
    if (v) begin
      cs_row[m_col] = cs;
      if (m_row >= 12 && m_col >= 12) begin
        e.v = 1'b1;
        for (int cc = m_col - 12; cc <= m_col; cc++) e.sum += cs_row[cc];
        if (mode == 0) e.cexp = 169 * cval;
        if (mode == 3) e.cexp = (m_row % 2 == 0) ? 1690 : 0;
      end
      if (m_col == W - 1) begin
        m_col = 0;
        if (m_row < H - 1) m_row++;
      end else begin
        m_col++;
      end
    end
    if (d) begin
      m_row = 0;
      m_col = 0;
    end
    @(posedge clk);
    #1;
    q.push_back(e);
    if (q.size() == 2) begin
      e = q.pop_front();
      check("valid_o", bus.valid_o, e.v);
      check("done_o", bus.done_o, e.d);
      if (e.v) begin
        vcnt[e.fid]++;
        check("sum_o", bus.sum_o, e.sum);
        if (e.cexp >= 0) check("sum_const", bus.sum_o, e.cexp);
      end
    end
  endtask

  task automatic run_frame(input int m, input int c, input int gap_pct,
                           input bit done_with_last, input int ncols);
    mode = m;
    cval = c;
    for (int n = 0; n < ncols; n++) begin
      if (int'($urandom_range(99)) < gap_pct) repeat ($urandom_range(1, 3)) step(1'b0, 1'b0);
      step(1'b1, done_with_last && (n == ncols - 1));
    end
    if (!done_with_last && ncols == W * H) step(1'b0, 1'b1);
    fid++;
  endtask

  initial begin
    for (int f = 0; f < NF; f++) vcnt[f] = 0;
    bus.valid_i = 1'b0;
    bus.done_i  = 1'b0;
    {bus.data12_i, bus.data11_i, bus.data10_i, bus.data9_i, bus.data8_i, bus.data7_i,
     bus.data6_i, bus.data5_i, bus.data4_i, bus.data3_i, bus.data2_i, bus.data1_i,
     bus.data0_i} = '0;
    #12;
    check("rst_sum", bus.sum_o, 16'd0);
    check("rst_valid", bus.valid_o, 1'b0);
    check("rst_done", bus.done_o, 1'b0);
    rst = 1'b1;

    run_frame(0, 1, 0, 1'b0, W * H);     // frame 0: all ones
    run_frame(0, 255, 0, 1'b1, W * H);   // frame 1: saturation, done with last column
    run_frame(3, 0, 0, 1'b0, W * H);     // frame 2: alternating 10/0 rows
    run_frame(1, 0, 50, 1'b0, W * H);    // frame 3: ramp, gapped
    run_frame(2, 0, 30, 1'b1, W * H);    // frame 4: random, gapped, done with last
    run_frame(1, 0, 0, 1'b0, 15 * W + 5); // frame 5: cut short by reset

    #2;
    rst = 1'b0;
    bus.valid_i = 1'b1;
    #1;
    check("midrst_sum", bus.sum_o, 16'd0);
    check("midrst_valid", bus.valid_o, 1'b0);
    check("midrst_done", bus.done_o, 1'b0);
    @(posedge clk);
    #1;
    check("hold_sum", bus.sum_o, 16'd0);
    check("hold_valid", bus.valid_o, 1'b0);
    check("hold_done", bus.done_o, 1'b0);
    rst = 1'b1;
    bus.valid_i = 1'b0;
    q.delete();
    m_row = 0;
    m_col = 0;

    run_frame(0, 1, 0, 1'b0, W * H);     // frame 6: all ones after reset
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    for (int f = 0; f < NF; f++) begin
      if (f != 5 && f < fid) check($sformatf("vcount_f%0d", f), vcnt[f], 25);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/box_sum_13x13.md
Name: box_sum_13x13

Overview:
- Downstream consumer of the 13-row line-buffer stage.
- Takes the 13 vertically aligned row taps, data0_i (newest row) through data12_i (oldest row), one column per valid_i strobe.
- Produces the running 13x13 box sum of the window, plus a valid strobe and a frame-done strobe for the filter stage that follows.
- Uses a pipelined column adder, then a sliding horizontal accumulator with subtract-oldest-column.

Parameters:
- IMG_W, 17: image width in pixels (columns per row). Must be ≥13.
- IMG_H, 17: image height in rows. Must be ≥13.
- CNT_W, 10: width of the row and column counters. Must satisfy 2^CNT_W > max(IMG_W, IMG_H).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- valid_i  in  1  one column of taps present this cycle.
- done_i  in  1  end-of-frame pulse from the line-buffer stage.
- data0_i … data12_i  in  8 each  row taps; data0_i is the newest row, data12_i the oldest.
- sum_o  out  16  13x13 window sum, unsigned.
- valid_o  out  1  sum_o holds a full-window result.
- done_o  out  1  end-of-frame pulse, aligned to the pipeline.

Behaviour:
- Reset: on rst low, asynchronously clear everything:
  - sum_o=0, valid_o=0, done_o=0;
  - all counters, the column-sum history, and the pipeline valid/done bits.
- Counters:
  - col advances on each valid_i. It wraps IMG_W-1→0, and on that wrap row increments.
  - row saturates at IMG_H-1.
  - done_i clears col and row on the next edge.
- Stage 1 (column sum):
  - colsum = sum of the 13 taps, 12 bits, registered.
  - Max value 13*255 = 3315, so no overflow.
  - Carries v1 = valid_i, plus c1 = col and r1 = row captured at input.
- Stage 2 (horizontal window):
  - 13-entry shift history of colsums, shifted only on v1.
  - When v1 and c1 == 0: acc = colsum and history is refilled from the new column. This is a row restart with no carry-over from the previous row.
  - Otherwise: acc = acc + colsum − history[12].
  - The history is cleared at the start of each row.
  - acc is 16 bits. Max 169*255 = 43095, so no overflow.
  - sum_o is the registered acc.
- valid_o:
  - Asserted the cycle after stage 2 when v1 and c1 ≥ 12 and r1 ≥ 12, i.e. the window is fully populated.
  - Otherwise 0.
- Latency: exactly 2 clocks from a valid_i column to the corresponding sum_o/valid_o.
- Gaps: valid_i may drop for any number of cycles. Pipeline state holds; no spurious valid_o is produced.
- done_o:
  - Is done_i delayed by exactly 2 clocks, one-cycle pulse.
  - Is independent of valid_i.
  - If done_i and valid_i coincide, the column is processed with the pre-clear counters, then the counters clear.
- Back-to-back frames: a new frame may start the cycle after done_i. Its first valid row is again row 12.
- Reset mid-frame: everything clears immediately. valid_o and done_o drop asynchronously. The next frame restarts at row 0, col 0.
- No backpressure: the downstream stage must accept one result per valid_o.

Decomposition:
- Shared package box_pkg holds:
  - constants NUM_ROWS=13, WIN=13, PIX_W=8, COLSUM_W=12, SUM_W=16;
  - the window-start index WIN-1.
- One sub-module, column_adder_13:
  - 13×8-bit inputs, 12-bit registered output, same clk/rst.
  - Internal adder tree with a single register stage; enable = valid_i.
- The top level holds the counters, history, accumulator and done delay.

Test Plan:
- Reset: drive rst=0 mid-stream with valid_i=1 → sum_o=0, valid_o=0, done_o=0 immediately, and held while rst=0.
- Constant frame: all taps = 1, 17x17 frame, continuous valid_i →
  - first valid_o at input row 12, col 12, two clocks later, with sum_o=169;
  - exactly 5x5 = 25 valid_o pulses per frame, all 169.
- Saturation: all taps = 255 → every valid result is sum_o = 43095, with no wrap.
- Row restart: row N taps = 10 and row N+1 taps = 0 at its start → the first valid result of row N+1 contains no contribution from row N's columns (sum_o = 0 where expected).
- Gapped input: random valid_i duty of 50% with ramp data → sum_o sequence identical to the gap-free golden model; valid_o count = 25.
- Done alignment: done_i pulse at cycle T → done_o high only at T+2; a new frame starting at T+1 produces its first valid_o at its own row 12, col 12.
